// File: rtl/skin_binarization_pkg.sv
// Shared constants for the skin-colour classifier: default thresholds and mask values.
// Latency: n/a (package only).
// Backpressure: n/a; the pipeline is stalled only by the clock enable.
package skin_binarization_pkg;

   typedef logic [7:0] pix_t;

   // Default rule thresholds. Strict (>) or inclusive bounds are applied in the modules.
   localparam pix_t DEF_R_MIN       = 8'd95;
   localparam pix_t DEF_G_MIN       = 8'd40;
   localparam pix_t DEF_B_MIN       = 8'd20;
   localparam pix_t DEF_SPREAD_MIN  = 8'd15;
   localparam pix_t DEF_RG_DIFF_MIN = 8'd15;
   localparam pix_t DEF_CB_MIN      = 8'd77;
   localparam pix_t DEF_CB_MAX      = 8'd127;
   localparam pix_t DEF_CR_MIN      = 8'd133;
   localparam pix_t DEF_CR_MAX      = 8'd173;
   localparam pix_t DEF_H_MAX       = 8'd50;
   localparam pix_t DEF_S_MIN       = 8'd23;
   localparam pix_t DEF_S_MAX       = 8'd170;

   localparam pix_t SKIN_ON  = 8'hFF;
   localparam pix_t SKIN_OFF = 8'h00;

endpackage

// File: rtl/skin_binarization_if.sv
// Pixel bus into and mask bus out of the skin classifier.
// Latency: n/a (wires only); outputs trail inputs by two ce-qualified edges.
// Backpressure: none; the source must honour the shared clock enable.
// Signals: de_in/hsync_in/vsync_in + R,G,B,H,S,Cb,Cr toward the classifier;
//          skin mask + de_out/hsync_out/vsync_out back from it.
interface skin_binarization_if;
   import skin_binarization_pkg::*;

   logic de_in;
   logic hsync_in;
   logic vsync_in;
   pix_t R;
   pix_t G;
   pix_t B;
   pix_t H;
   pix_t S;
   pix_t Cb;
   pix_t Cr;

   pix_t skin;
   logic de_out;
   logic hsync_out;
   logic vsync_out;

   // Video source / sink side
   modport master (
      output de_in, hsync_in, vsync_in, R, G, B, H, S, Cb, Cr,
      input  skin, de_out, hsync_out, vsync_out
   );

   // Classifier side
   modport slave (
      input  de_in, hsync_in, vsync_in, R, G, B, H, S, Cb, Cr,
      output skin, de_out, hsync_out, vsync_out
   );
endinterface

// File: rtl/skin_rgb_rule.sv
// Combinational RGB skin test: per-channel floors, red dominance, channel spread and |R-G|.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: r, g, b (8-bit unsigned) in; rgb_ok out.
module skin_rgb_rule
   import skin_binarization_pkg::*;
#(
   parameter pix_t R_MIN       = DEF_R_MIN,
   parameter pix_t G_MIN       = DEF_G_MIN,
   parameter pix_t B_MIN       = DEF_B_MIN,
   parameter pix_t SPREAD_MIN  = DEF_SPREAD_MIN,
   parameter pix_t RG_DIFF_MIN = DEF_RG_DIFF_MIN
) (
   input  pix_t r,
   input  pix_t g,
   input  pix_t b,
   output logic rgb_ok
);

   pix_t ch_max;
   pix_t ch_min;
   pix_t spread;
   pix_t rg_diff;

   always_comb begin
      ch_max = r;
      if (g > ch_max) ch_max = g;
      if (b > ch_max) ch_max = b;
      ch_min = r;
      if (g < ch_min) ch_min = g;
      if (b < ch_min) ch_min = b;
      // Ordered subtractions: larger minus smaller, so the 8-bit result never wraps.
      spread  = ch_max - ch_min;
      rg_diff = (r >= g) ? (r - g) : (g - r);
      rgb_ok  = (r > R_MIN) && (g > G_MIN) && (b > B_MIN) &&
                (r > g) && (r > b) &&
                (spread > SPREAD_MIN) && (rg_diff > RG_DIFF_MIN);
   end

endmodule

// File: rtl/skin_binarization.sv
// Per-pixel skin classifier producing an 8-bit binary mask from RGB, CbCr and HS rules.
// Latency: 2 ce-qualified clk edges; de/hsync/vsync delayed by the same amount.
// Backpressure: none; ce=0 freezes every register and ignores the inputs.
// Ports: clk, rst_n (async active-low), ce; pix (slave modport) carries the pixel and timing
//        in and the skin mask plus delayed timing out.
module skin_binarization
   import skin_binarization_pkg::*;
#(
   parameter pix_t R_MIN       = DEF_R_MIN,
   parameter pix_t G_MIN       = DEF_G_MIN,
   parameter pix_t B_MIN       = DEF_B_MIN,
   parameter pix_t SPREAD_MIN  = DEF_SPREAD_MIN,
   parameter pix_t RG_DIFF_MIN = DEF_RG_DIFF_MIN,
   parameter pix_t CB_MIN      = DEF_CB_MIN,
   parameter pix_t CB_MAX      = DEF_CB_MAX,
   parameter pix_t CR_MIN      = DEF_CR_MIN,
   parameter pix_t CR_MAX      = DEF_CR_MAX,
   parameter pix_t H_MAX       = DEF_H_MAX,
   parameter pix_t S_MIN       = DEF_S_MIN,
   parameter pix_t S_MAX       = DEF_S_MAX
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   skin_binarization_if.slave   pix
);

   logic rgb_ok_c;
   logic ycc_ok_c;
   logic hs_ok_c;

   logic rgb_ok_s1;
   logic ycc_ok_s1;
   logic hs_ok_s1;
   logic de_s1;
   logic hsync_s1;
   logic vsync_s1;

   pix_t skin_s2;
   logic de_s2;
   logic hsync_s2;
   logic vsync_s2;

   skin_rgb_rule #(
      .R_MIN       (R_MIN),
      .G_MIN       (G_MIN),
      .B_MIN       (B_MIN),
      .SPREAD_MIN  (SPREAD_MIN),
      .RG_DIFF_MIN (RG_DIFF_MIN)
   ) u_rgb_rule (
      .r      (pix.R),
      .g      (pix.G),
      .b      (pix.B),
      .rgb_ok (rgb_ok_c)
   );

   always_comb begin
      ycc_ok_c = (pix.Cb >= CB_MIN) && (pix.Cb <= CB_MAX) &&
                 (pix.Cr >= CR_MIN) && (pix.Cr <= CR_MAX);
      hs_ok_c  = (pix.H <= H_MAX) &&
                 (pix.S >= S_MIN) && (pix.S <= S_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_ok_s1 <= 1'b0;
         ycc_ok_s1 <= 1'b0;
         hs_ok_s1  <= 1'b0;
         de_s1     <= 1'b0;
         hsync_s1  <= 1'b0;
         vsync_s1  <= 1'b0;
         skin_s2   <= SKIN_OFF;
         de_s2     <= 1'b0;
         hsync_s2  <= 1'b0;
         vsync_s2  <= 1'b0;
      end else if (ce) begin
         rgb_ok_s1 <= rgb_ok_c;
         ycc_ok_s1 <= ycc_ok_c;
         hs_ok_s1  <= hs_ok_c;
         de_s1     <= pix.de_in;
         hsync_s1  <= pix.hsync_in;
         vsync_s1  <= pix.vsync_in;
         // Gating with de forces the mask to zero during blanking.
         skin_s2   <= (rgb_ok_s1 && ycc_ok_s1 && hs_ok_s1 && de_s1) ? SKIN_ON : SKIN_OFF;
         de_s2     <= de_s1;
         hsync_s2  <= hsync_s1;
         vsync_s2  <= vsync_s1;
      end
   end

   assign pix.skin      = skin_s2;
   assign pix.de_out    = de_s2;
   assign pix.hsync_out = hsync_s2;
   assign pix.vsync_out = vsync_s2;

endmodule

// File: tb/tb_skin_binarization.sv
// Directed + randomised bench for skin_binarization with an expected-result queue.
// Latency: checks outputs two ce-qualified edges after each accepted pixel.
// Backpressure: ce is toggled to exercise pipeline freezing.
module tb_skin_binarization;

   typedef struct packed {
      logic [7:0] r, g, b, cb, cr, h, s;
      logic       de, hs, vs;
   } px_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ce;

   skin_binarization_if pif ();

   skin_binarization dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .pix   (pif)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [10:0] exp_q[$];
   string       tag_q[$];
   logic [10:0] last_exp;

   function automatic px_t mk(int r, int g, int b, int cb, int cr, int h, int s,
                              logic de, logic hs, logic vs);
      px_t p;
      p.r = 8'(r); p.g = 8'(g); p.b = 8'(b);
      p.cb = 8'(cb); p.cr = 8'(cr); p.h = 8'(h); p.s = 8'(s);
      p.de = de; p.hs = hs; p.vs = vs;
      return p;
   endfunction

   function automatic logic [10:0] ex(logic [7:0] skin, px_t p);
      return {skin, p.de, p.hs, p.vs};
   endfunction

   // Reference classifier written independently in plain integer arithmetic.
   function automatic logic [7:0] model(px_t p);
      int r, g, b, mx, mn, d;
      bit ok;
      r = int'(p.r); g = int'(p.g); b = int'(p.b);
      mx = (r > g) ? r : g; mx = (b > mx) ? b : mx;
      mn = (r < g) ? r : g; mn = (b < mn) ? b : mn;
      d  = (r > g) ? r - g : g - r;
      ok = (r > 95) && (g > 40) && (b > 20) && (r > g) && (r > b) &&
           (mx - mn > 15) && (d > 15) &&
           (int'(p.cb) >= 77) && (int'(p.cb) <= 127) &&
           (int'(p.cr) >= 133) && (int'(p.cr) <= 173) &&
           (int'(p.h) <= 50) && (int'(p.s) >= 23) && (int'(p.s) <= 170) && p.de;
      return ok ? 8'hFF : 8'h00;
   endfunction

   function automatic logic [7:0] jit(int base);
      int v;
      if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
      v = base + int'($urandom_range(0, 40)) - 20;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      return 8'(v);
   endfunction

   function automatic logic [10:0] observed();
      return {pif.skin, pif.de_out, pif.hsync_out, pif.vsync_out};
   endfunction

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed skin=%h de/hs/vs=%b expected skin=%h de/hs/vs=%b",
                tag, obs[10:3], obs[2:0], expv[10:3], expv[2:0]);
      end
   endtask

   task automatic drive(input px_t p);
      pif.R = p.r; pif.G = p.g; pif.B = p.b;
      pif.Cb = p.cb; pif.Cr = p.cr; pif.H = p.h; pif.S = p.s;
      pif.de_in = p.de; pif.hsync_in = p.hs; pif.vsync_in = p.vs;
   endtask

   // One clock of stimulus. With ce=1 the pixel's expectation is queued and the
   // pixel accepted one ce-edge earlier is compared; with ce=0 outputs must hold.
   task automatic step(input px_t p, input logic c, input logic [10:0] expv, input string tag);
      logic [10:0] e;
      string       t;
      @(negedge clk);
      drive(p);
      ce = c;
      if (c) begin
         exp_q.push_back(expv);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      if (c) begin
         if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, observed(), e);
            last_exp = e;
         end
      end else begin
         check("ce_hold", observed(), last_exp);
      end
   endtask

   initial begin
      px_t s1, s2, n1, n2, p;
      logic c;

      s1 = mk(222, 151, 99, 90, 168, 25, 55, 1'b1, 1'b0, 1'b0);
      s2 = mk(148, 99, 56, 98, 156, 28, 62, 1'b1, 1'b1, 1'b0);
      n1 = mk(15, 187, 54, 91, 53, 134, 92, 1'b1, 1'b0, 1'b1);
      n2 = mk(50, 66, 63, 129, 120, 169, 24, 1'b1, 1'b0, 1'b0);
      last_exp = '0;

      // Reset held with an active skin pixel on the inputs
      rst_n = 1'b0;
      ce    = 1'b1;
      drive(mk(222, 151, 99, 90, 168, 25, 55, 1'b1, 1'b1, 1'b1));
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_hold", observed(), 11'h000);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Skin and non-skin pixels with varying timing
      step(s1, 1'b1, ex(8'hFF, s1), "skin1");
      step(s2, 1'b1, ex(8'hFF, s2), "skin2");
      step(n1, 1'b1, ex(8'h00, n1), "nonskin1");
      step(n2, 1'b1, ex(8'h00, n2), "nonskin2");
      for (int i = 0; i < 6; i++) begin
         p = n1;
         p.de = i[0]; p.hs = ~i[0]; p.vs = i[1];
         step(p, 1'b1, ex(8'h00, p), "timing");
      end

      // Blanking: a skin-coloured pixel outside the active area
      p = s1; p.de = 1'b0;
      step(p, 1'b1, ex(8'h00, p), "blank");

      // R floor: G and B lowered so R remains the dominant channel at 95/96
      p = s1; p.r = 8'd95; p.g = 8'd60; p.b = 8'd30; step(p, 1'b1, ex(8'h00, p), "r95");
      p = s1; p.r = 8'd96; p.g = 8'd60; p.b = 8'd30; step(p, 1'b1, ex(8'hFF, p), "r96");
      p = s1; p.r = 8'd150; p.g = 8'd40; p.b = 8'd30; step(p, 1'b1, ex(8'h00, p), "g40");
      p = s1; p.r = 8'd150; p.g = 8'd41; p.b = 8'd30; step(p, 1'b1, ex(8'hFF, p), "g41");
      p = s1; p.b = 8'd20; step(p, 1'b1, ex(8'h00, p), "b20");
      p = s1; p.b = 8'd21; step(p, 1'b1, ex(8'hFF, p), "b21");
      p = s1; p.r = 8'd120; p.g = 8'd105; p.b = 8'd50; step(p, 1'b1, ex(8'h00, p), "rg15");
      p = s1; p.r = 8'd120; p.g = 8'd104; p.b = 8'd50; step(p, 1'b1, ex(8'hFF, p), "rg16");
      p = s1; p.cb = 8'd77;  step(p, 1'b1, ex(8'hFF, p), "cb77");
      p = s1; p.cb = 8'd76;  step(p, 1'b1, ex(8'h00, p), "cb76");
      p = s1; p.cb = 8'd127; step(p, 1'b1, ex(8'hFF, p), "cb127");
      p = s1; p.cb = 8'd128; step(p, 1'b1, ex(8'h00, p), "cb128");
      p = s1; p.cr = 8'd173; step(p, 1'b1, ex(8'hFF, p), "cr173");
      p = s1; p.cr = 8'd174; step(p, 1'b1, ex(8'h00, p), "cr174");
      p = s1; p.cr = 8'd133; step(p, 1'b1, ex(8'hFF, p), "cr133");
      p = s1; p.cr = 8'd132; step(p, 1'b1, ex(8'h00, p), "cr132");
      p = s1; p.h = 8'd50;   step(p, 1'b1, ex(8'hFF, p), "h50");
      p = s1; p.h = 8'd51;   step(p, 1'b1, ex(8'h00, p), "h51");
      p = s1; p.s = 8'd23;   step(p, 1'b1, ex(8'hFF, p), "s23");
      p = s1; p.s = 8'd22;   step(p, 1'b1, ex(8'h00, p), "s22");
      p = s1; p.s = 8'd170;  step(p, 1'b1, ex(8'hFF, p), "s170");
      p = s1; p.s = 8'd171;  step(p, 1'b1, ex(8'h00, p), "s171");

      // Clock enable: skin pixel accepted, then 5 frozen cycles with non-skin inputs
      step(s1, 1'b1, ex(8'hFF, s1), "ce_skin");
      for (int i = 0; i < 5; i++) step(n1, 1'b0, 11'h000, "ce_hold");
      step(n2, 1'b1, ex(8'h00, n2), "ce_resume1");
      step(n1, 1'b1, ex(8'h00, n1), "ce_resume2");

      // Asynchronous reset in mid-stream while the mask is high
      step(s1, 1'b1, ex(8'hFF, s1), "pre_rst1");
      step(s2, 1'b1, ex(8'hFF, s2), "pre_rst2");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", observed(), 11'h000);
      exp_q.delete();
      tag_q.delete();
      last_exp = '0;
      @(posedge clk);
      #1;
      check("reset_mid_hold", observed(), 11'h000);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised pixels near the skin cluster with random ce
      for (int i = 0; i < 300; i++) begin
         p.r = jit(200); p.g = jit(140); p.b = jit(90);
         p.cb = jit(100); p.cr = jit(160); p.h = jit(35); p.s = jit(60);
         p.de = ($urandom_range(0, 7) != 0);
         p.hs = 1'($urandom_range(0, 1));
         p.vs = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 3) != 0);
         step(p, c, ex(model(p), p), "random");
      end

      // Drain the last queued pixel
      step(n2, 1'b1, ex(8'h00, n2), "flush1");
      step(n2, 1'b1, ex(8'h00, n2), "flush2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/skin_binarization.md
Name: skin_binarization

Overview:
Per-pixel skin-colour classifier in the video processing chain, placed after the colour-space converters that produce HSV and YCbCr alongside RGB. It tests each pixel against three rule sets (RGB, CbCr, HS) and outputs an 8-bit binary mask pixel: 0xFF for skin, 0x00 otherwise. Video timing signals (de, hsync, vsync) are delayed to stay aligned with the mask.

Parameters:
R_MIN, 95, R must be strictly greater
G_MIN, 40, G must be strictly greater
B_MIN, 20, B must be strictly greater
SPREAD_MIN, 15, max(R,G,B)-min(R,G,B) must be strictly greater
RG_DIFF_MIN, 15, |R-G| must be strictly greater
CB_MIN / CB_MAX, 77 / 127, inclusive Cb window
CR_MIN / CR_MAX, 133 / 173, inclusive Cr window
H_MAX, 50, H must be <= (8-bit hue scale)
S_MIN / S_MAX, 23 / 170, inclusive S window

Ports:
clk  in  1  pixel clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; pipeline advances only when 1
de_in  in  1  data enable, aligned with pixel inputs
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
R, G, B  in  8 each  RGB components, unsigned
H, S  in  8 each  hue and saturation, unsigned
Cb, Cr  in  8 each  chroma components, unsigned
skin  out  8  mask pixel: 0xFF skin, 0x00 non-skin
de_out, hsync_out, vsync_out  out  1 each  timing delayed to match skin

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: all pipeline registers clear. skin=0x00 and de_out=hsync_out=vsync_out=0 while rst_n=0, and immediately on assertion, even in mid-frame.
- Latency: 2 ce-qualified rising edges, input to output.
- Stage 1 registers:
  - rgb_ok = R>R_MIN & G>G_MIN & B>B_MIN & R>G & R>B & (max-min)>SPREAD_MIN & |R-G|>RG_DIFF_MIN.
  - ycc_ok = CB_MIN<=Cb<=CB_MAX & CR_MIN<=Cr<=CR_MAX.
  - hs_ok = H<=H_MAX & S_MIN<=S<=S_MAX.
  - de, hsync and vsync.
- Stage 2 registers skin = (rgb_ok & ycc_ok & hs_ok & de_s1) ? 0xFF : 0x00, plus timing.
- Blanking: the mask is always 0x00 when de is low.
- Arithmetic: all comparisons unsigned. Differences are computed at 9 bits, or as ordered subtraction, so there is no wrap-around. |R-G| uses the larger value minus the smaller.
- ce=0: every register holds its value, outputs are frozen, and input changes are ignored. ce may toggle on any cycle.
- Syncs pass through unmodified, with polarity unchanged.

Decomposition:
- Shared package: default threshold constants and the 8-bit mask constants SKIN_ON=8'hFF and SKIN_OFF=8'h00.
- One sub-module is natural: skin_rgb_rule, a combinational RGB test (max/min spread, |R-G|, ordering). The CbCr and HS window checks stay inline.

Test Plan:
- Reset: hold rst_n=0 with active inputs -> all outputs 0. Assert rst_n=0 mid-stream -> outputs clear immediately, asynchronously.
- Skin pixels, ce=1, de=1: (R222,G151,B99,Cb90,Cr168,H25,S55) followed by (R148,G99,B56,Cb98,Cr156,H28,S62) -> skin=0xFF on each, 2 cycles later; de_out, hsync_out and vsync_out match the inputs delayed by 2 cycles.
- Non-skin pixels:
  - (R15,G187,B54,Cb91,Cr53,H134,S92) -> 0x00.
  - (R50,G66,B63,Cb129,Cr120,H169,S24) -> 0x00.
  - An alternating de/hsync/vsync sequence appears at the outputs with 2-cycle delay.
- Blanking: the first skin pixel with de_in=0 -> skin=0x00, de_out=0.
- Thresholds, starting from skin pixel 1:
  - R=95 -> 0x00; R=96 -> 0xFF.
  - Cb=77 -> 0xFF; Cb=76 -> 0x00.
  - Cr=173 -> 0xFF; Cr=174 -> 0x00.
  - H=50 -> 0xFF; H=51 -> 0x00.
  - S=23 -> 0xFF; S=22 -> 0x00.
- Clock enable: present a skin pixel, drop ce for 5 cycles while changing the inputs to non-skin -> outputs frozen at the prior values. Raise ce -> the pipeline resumes, and the skin pixel emerges after 2 ce cycles in total.
